par2sep_pixel: RTL and testbench
================================

# par2sep_pixel

Parallel-to-serial pixel unpacker: accepts one packed word of SHIFT_WIDTH pixels per valid/ready handshake and emits the pixels one per clock, first-written pixel first. It is the inverse of the pixel packer (sep2par) and feeds per-pixel consumers such as the colour-bar/scaler pixel stages from a wide-bus source such as a DDR read path or a line buffer. A one-word holding register keeps the output streaming without gaps across word boundaries.

## Interface
- SEP_DATA_WIDTH, 24: bits per pixel.
- SHIFT_WIDTH, 8: pixels per packed word; must be at least 2.
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous discard of all buffered pixels; same effect as rst on the datapath state.
- din  in  SHIFT_WIDTH*SEP_DATA_WIDTH  packed word; pixel 0 (first out) sits at [SHIFT_WIDTH*SEP_DATA_WIDTH-1 -: SEP_DATA_WIDTH], pixel SHIFT_WIDTH-1 at [SEP_DATA_WIDTH-1:0].
- din_valid  in  1  din is valid.
- din_ready  out  1  word is accepted on a cycle with din_valid && din_ready.
- dout  out  SEP_DATA_WIDTH  current pixel.
- dout_valid  out  1  dout is valid.
- dout_ready  in  1  downstream accepts; pixel transfers when dout_valid && dout_ready.
- dout_sof  out  1  high with pixel 0 of each word; acts as the packer's sync.

## Operation
- Datapath: shifter (SHIFT_WIDTH*SEP_DATA_WIDTH), pixel counter cnt (clog2(SHIFT_WIDTH) bits), holding register hold plus hold_v.
- dout is always the top SEP_DATA_WIDTH bits of the shifter. On each transfer, the shifter shifts left by SEP_DATA_WIDTH (zero fill) and cnt increments.
- States:
  - EMPTY: dout_valid=0, din_ready=1. Accept -> load the shifter, cnt=0 -> BUSY.
  - BUSY: dout_valid=1, hold empty, din_ready=1.
    - Accept with no last-pixel transfer -> word goes to hold -> FULL.
    - Last-pixel transfer (cnt==SHIFT_WIDTH-1) with accept -> load the shifter directly from din, stay in BUSY.
    - Last-pixel transfer without accept -> EMPTY.
  - FULL: dout_valid=1, din_ready=0. Last-pixel transfer -> load the shifter from hold, clear hold_v -> BUSY.
- dout_sof = dout_valid && cnt==0.
- Wrap-around: cnt returns to 0 on every word load. cnt never exceeds SHIFT_WIDTH-1.
- Back-pressure: with dout_ready=0, dout, dout_sof and cnt are held stable. An accept into hold is still allowed in BUSY.
- flush or rst: go to EMPTY, clear cnt and hold_v, zero the shifter. Any input accepted on the same cycle is discarded. rst has priority over flush.

## Timing
- Reset values: dout=0, dout_valid=0, dout_sof=0, din_ready=1 in the cycle after rst.
- din_ready is a combinational decode of the state register only. It has no combinational path from din_valid or dout_ready.
- dout, dout_valid and dout_sof are registered or decoded from registers only.
- Latency: a word accepted at edge N gives pixel 0 valid in the cycle after N, when it enters from EMPTY.
- Throughput: one pixel per clock while dout_ready=1. With din_valid held high, the last pixel of word k is followed directly by pixel 0 of word k+1, with no bubble.
- Simultaneous accept and last-pixel transfer in BUSY: the shifter loads din and no hold is used.
- Simultaneous flush and accept: the word is dropped and din_ready stays 1.

## Structure
- A shared package pix_pkg holds:
  - the EMPTY/BUSY/FULL state enum;
  - default SEP_DATA_WIDTH and SHIFT_WIDTH constants, shared with sep2par;
  - a PIX_CNT_W function, clog2(SHIFT_WIDTH).
- One natural sub-module: pix_hold_reg, a single-entry holding register with valid, load, unload and clear. It is instantiated once. The shifter and counter stay in the top level.

## Test plan
- Reset then idle: after rst, dout=0, dout_valid=0, din_ready=1.
  - Word 0x000001_000002_…_000008 accepted -> dout reads 000001..000008 on 8 consecutive cycles.
  - dout_sof is high only with 000001.
- Back-to-back: din_valid=1 for 3 words, dout_ready=1.
  - 24 contiguous valid pixels with no gap.
  - dout_sof on pixels 0, 8 and 16.
  - din_ready drops to 0 while hold is full.
- Back-pressure: dout_ready toggled 1,0,0,1 on every pixel.
  - dout stays stable while stalled.
  - No pixel is lost or duplicated; order is 1..8.
- Round-trip: the sep2par output word is fed into this block -> the original 24-bit sequence is reproduced in order.
- Flush mid-word: flush at pixel 3 while hold is full -> next cycle dout_valid=0 and din_ready=1.
  - The next word starts at its pixel 0 with dout_sof=1.
- rst mid-word while in FULL -> same as the flush case. A word offered on the rst cycle is not emitted.

Source files
------------

// File: rtl/pix_pkg.sv
// Shared pixel-stream definitions for the packer (sep2par) and unpacker (par2sep_pixel).
//   - pix_state_e        : unpacker buffer occupancy state
//   - *_DEF constants    : default pixel width and pixels per packed word
//   - PIX_CNT_W()        : width of a pixel index within one packed word
package pix_pkg;

  localparam int unsigned SEP_DATA_WIDTH_DEF = 24;
  localparam int unsigned SHIFT_WIDTH_DEF    = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } pix_state_e;

  // Pixel index width; shift_width is at least 2, so this is at least 1.
  function automatic int unsigned PIX_CNT_W(input int unsigned shift_width);
    return $clog2(shift_width);
  endfunction

endpackage

// File: rtl/par2sep_pixel_if.sv
// Packed-word input / pixel output stream bundle for par2sep_pixel.
//   din/din_valid/din_ready        : packed word in, valid/ready handshake
//   dout/dout_valid/dout_ready     : one pixel out, valid/ready handshake
//   dout_sof                       : marks pixel 0 of each word
// slave is the unpacker's view, master is the source/sink side.
interface par2sep_pixel_if import pix_pkg::*; #(
  parameter int unsigned SEP_DATA_WIDTH = SEP_DATA_WIDTH_DEF,
  parameter int unsigned SHIFT_WIDTH    = SHIFT_WIDTH_DEF
);

  localparam int unsigned WORD_W = SHIFT_WIDTH * SEP_DATA_WIDTH;

  logic [WORD_W-1:0]         din;
  logic                      din_valid;
  logic                      din_ready;
  logic [SEP_DATA_WIDTH-1:0] dout;
  logic                      dout_valid;
  logic                      dout_ready;
  logic                      dout_sof;

  modport slave (
    input  din, din_valid, dout_ready,
    output din_ready, dout, dout_valid, dout_sof
  );

  modport master (
    output din, din_valid, dout_ready,
    input  din_ready, dout, dout_valid, dout_sof
  );

endinterface

// File: rtl/pix_hold_reg.sv
// Single-entry holding register with a valid flag.
//   clk, rst : clock and synchronous active-high reset
//   clear    : synchronous discard (same effect as rst)
//   load     : capture d and set valid (wins over unload)
//   unload   : drop valid once the entry has been consumed
//   d / q    : data in / held data
//   valid    : entry occupied
module pix_hold_reg #(
  parameter int unsigned WIDTH = 192
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic             unload,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             valid
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (unload) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/par2sep_pixel.sv
// Parallel-to-serial pixel unpacker: takes one packed word of SHIFT_WIDTH pixels
// per handshake and emits one pixel per clock, pixel 0 (MSB slice) first. A
// one-word holding register lets the next word queue up so consecutive words
// stream with no bubble.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   flush : synchronous discard of all buffered pixels
//   bus   : par2sep_pixel_if.slave (din/din_valid/din_ready, dout/dout_valid/dout_ready/dout_sof)
module par2sep_pixel import pix_pkg::*; #(
  parameter int unsigned SEP_DATA_WIDTH = SEP_DATA_WIDTH_DEF,
  parameter int unsigned SHIFT_WIDTH    = SHIFT_WIDTH_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  par2sep_pixel_if.slave  bus
);

  localparam int unsigned WORD_W = SHIFT_WIDTH * SEP_DATA_WIDTH;
  localparam int unsigned CNT_W  = PIX_CNT_W(SHIFT_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SHIFT_WIDTH - 1);

  pix_state_e        state;
  logic [WORD_W-1:0] shifter;
  logic [WORD_W-1:0] shifted;
  logic [WORD_W-1:0] hold_q;
  logic [CNT_W-1:0]  cnt;
  logic              hold_v;
  logic              accept;
  logic              xfer;
  logic              last_xfer;
  logic              hold_load;
  logic              hold_unload;

  // Outputs decode from registers only; din_ready has no path from din_valid/dout_ready.
  assign bus.din_ready  = (state != FULL);
  assign bus.dout_valid = (state != EMPTY);
  assign bus.dout       = shifter[WORD_W-1 -: SEP_DATA_WIDTH];
  assign bus.dout_sof   = bus.dout_valid && (cnt == '0);

  assign accept    = bus.din_valid && bus.din_ready;
  assign xfer      = bus.dout_valid && bus.dout_ready;
  assign last_xfer = xfer && (cnt == CNT_LAST);
  assign shifted   = {shifter[WORD_W-SEP_DATA_WIDTH-1:0], {SEP_DATA_WIDTH{1'b0}}};

  // Park a word only when the shifter cannot take it directly this cycle.
  assign hold_load   = (state == BUSY) && accept && !last_xfer;
  assign hold_unload = (state == FULL) && hold_v && last_xfer;

  pix_hold_reg #(
    .WIDTH (WORD_W)
  ) u_hold (
    .clk    (clk),
    .rst    (rst),
    .clear  (flush),
    .load   (hold_load),
    .unload (hold_unload),
    .d      (bus.din),
    .q      (hold_q),
    .valid  (hold_v)
  );

  // Buffer-occupancy FSM with shifter and pixel counter.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state   <= EMPTY;
      cnt     <= '0;
      shifter <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            shifter <= bus.din;
            cnt     <= '0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (last_xfer) begin
            cnt <= '0;
            if (accept) begin
              shifter <= bus.din;
            end else begin
              shifter <= shifted;
              state   <= EMPTY;
            end
          end else begin
            if (xfer) begin
              shifter <= shifted;
              cnt     <= cnt + CNT_W'(1);
            end
            if (accept) begin
              state <= FULL;
            end
          end
        end
        FULL: begin
          if (hold_unload) begin
            shifter <= hold_q;
            cnt     <= '0;
            state   <= BUSY;
          end else if (xfer) begin
            shifter <= shifted;
            cnt     <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_par2sep_pixel.sv
// Directed self-checking bench for par2sep_pixel. Inputs change and outputs
// are sampled on the falling edge, half a cycle away from the active edge.
module tb_par2sep_pixel;

  localparam int unsigned SW = 24;
  localparam int unsigned NP = 8;
  localparam int unsigned WW = SW * NP;

  logic clk;
  logic rst;
  logic flush;
  int   tests;
  int   fails;

  par2sep_pixel_if #(.SEP_DATA_WIDTH(SW), .SHIFT_WIDTH(NP)) bus ();

  par2sep_pixel #(.SEP_DATA_WIDTH(SW), .SHIFT_WIDTH(NP)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // Packed word whose pixel i (pixel 0 in the MSB slice) is base+i.
  function automatic logic [WW-1:0] make_word(input logic [SW-1:0] base);
    logic [WW-1:0] w;
    w = '0;
    for (int i = 0; i < int'(NP); i++) w[WW-1-i*SW -: SW] = base + SW'(i);
    return w;
  endfunction

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0;
    bus.din = '0; bus.din_valid = 1'b0; bus.dout_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tests++;
    if (bus.dout !== '0 || bus.dout_valid !== 1'b0 || bus.dout_sof !== 1'b0 || bus.din_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset: got dout=%h valid=%b sof=%b ready=%b, want 0 0 0 1",
               bus.dout, bus.dout_valid, bus.dout_sof, bus.din_ready);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (bus.dout_valid !== 1'b0 || bus.din_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_idle: got valid=%b ready=%b, want 0 1", bus.dout_valid, bus.din_ready);
    end
  endtask

  task automatic test_single_word();
    logic exp_sof;
    bus.din = make_word(24'h000001); bus.din_valid = 1'b1; bus.dout_ready = 1'b1;
    @(negedge clk);
    bus.din_valid = 1'b0;
    for (int i = 0; i < int'(NP); i++) begin
      exp_sof = (i == 0);
      tests++;
      if (bus.dout_valid !== 1'b1 || bus.dout !== SW'(i + 1) || bus.dout_sof !== exp_sof) begin
        fails++;
        $display("FAIL single_word px%0d: got valid=%b dout=%h sof=%b, want 1 %h %b",
                 i, bus.dout_valid, bus.dout, bus.dout_sof, SW'(i + 1), exp_sof);
      end
      @(negedge clk);
    end
    tests++;
    if (bus.dout_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_word_end: got valid=%b, want 0", bus.dout_valid);
    end
  endtask

  task automatic test_back_to_back();
    int   wi;
    int   n;
    bit   started;
    bit   saw_ready_low;
    bit   pend;
    logic [SW-1:0] exp_px;
    logic exp_sof;
    wi = 0; n = 0; started = 0; saw_ready_low = 0;
    bus.dout_ready = 1'b1;
    bus.din = make_word(24'h100000); bus.din_valid = 1'b1;
    pend = bus.din_valid && bus.din_ready;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (pend) wi++;
      if (bus.din_ready === 1'b0) saw_ready_low = 1;
      if (started && n < 24) begin
        tests++;
        if (bus.dout_valid !== 1'b1) begin
          fails++;
          $display("FAIL b2b_gap before px%0d: got valid=%b, want 1", n, bus.dout_valid);
        end
      end
      if (bus.dout_valid === 1'b1 && n < 24) begin
        started = 1;
        exp_px  = SW'(32'h100000 * (n / 8 + 1) + n % 8);
        exp_sof = (n % 8 == 0);
        tests++;
        if (bus.dout !== exp_px || bus.dout_sof !== exp_sof) begin
          fails++;
          $display("FAIL b2b px%0d: got dout=%h sof=%b, want %h %b", n, bus.dout, bus.dout_sof, exp_px, exp_sof);
        end
        n++;
      end
      if (n == 24) break;
      if (wi < 3) begin
        bus.din = make_word(SW'(32'h100000 * (wi + 1)));
        bus.din_valid = 1'b1;
      end else begin
        bus.din_valid = 1'b0;
      end
      pend = bus.din_valid && bus.din_ready;
    end
    bus.din_valid = 1'b0;
    tests++;
    if (n != 24) begin
      fails++;
      $display("FAIL b2b_count: got %0d pixels, want 24", n);
    end
    tests++;
    if (!saw_ready_low) begin
      fails++;
      $display("FAIL b2b_ready: got din_ready never low, want low while hold full");
    end
    @(negedge clk);
    tests++;
    if (bus.dout_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_drain: got valid=%b, want 0", bus.dout_valid);
    end
  endtask

  task automatic test_back_pressure();
    logic [3:0]    pat;
    logic          rdy;
    bit            prev_stall;
    logic [SW-1:0] prev_dout;
    logic          prev_sof;
    logic          exp_sof;
    int            n;
    pat = 4'b1001; n = 0; prev_stall = 0; prev_dout = '0; prev_sof = 1'b0;
    bus.dout_ready = 1'b0;
    bus.din = make_word(24'h000001); bus.din_valid = 1'b1;
    @(negedge clk);
    bus.din_valid = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (n == 8) break;
      if (prev_stall) begin
        tests++;
        if (bus.dout_valid !== 1'b1 || bus.dout !== prev_dout || bus.dout_sof !== prev_sof) begin
          fails++;
          $display("FAIL bp_stable: got valid=%b dout=%h sof=%b, want 1 %h %b",
                   bus.dout_valid, bus.dout, bus.dout_sof, prev_dout, prev_sof);
        end
      end
      rdy = pat[cyc % 4];
      bus.dout_ready = rdy;
      if (bus.dout_valid === 1'b1 && rdy) begin
        exp_sof = (n == 0);
        tests++;
        if (bus.dout !== SW'(n + 1) || bus.dout_sof !== exp_sof) begin
          fails++;
          $display("FAIL bp_order px%0d: got dout=%h sof=%b, want %h %b", n, bus.dout, bus.dout_sof, SW'(n + 1), exp_sof);
        end
        n++;
      end
      prev_stall = (bus.dout_valid === 1'b1) && !rdy;
      prev_dout  = bus.dout;
      prev_sof   = bus.dout_sof;
      @(negedge clk);
    end
    tests++;
    if (n != 8 || bus.dout_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_count: got %0d pixels valid=%b, want 8 and 0", n, bus.dout_valid);
    end
    bus.dout_ready = 1'b1;
  endtask

  task automatic test_round_trip();
    logic [SW-1:0] rt [16];
    logic [WW-1:0] words [2];
    int  wi;
    int  n;
    bit  pend;
    rt = '{24'h123456, 24'hABCDEF, 24'h000000, 24'hFFFFFF, 24'h800001, 24'h0F0F0F, 24'hF0F0F0, 24'h555555,
           24'hAAAAAA, 24'h00FF00, 24'hFF00FF, 24'h7FFFFF, 24'h000100, 24'hC0FFEE, 24'hDEAD00, 24'h00BEEF};
    // Pack as the packer would: first pixel in the top slice.
    for (int k = 0; k < 2; k++) begin
      words[k] = '0;
      for (int i = 0; i < int'(NP); i++) words[k][WW-1-i*SW -: SW] = rt[k*8+i];
    end
    wi = 0; n = 0;
    bus.dout_ready = 1'b1;
    bus.din = words[0]; bus.din_valid = 1'b1;
    pend = bus.din_ready;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (pend) wi++;
      if (bus.dout_valid === 1'b1 && n < 16) begin
        tests++;
        if (bus.dout !== rt[n]) begin
          fails++;
          $display("FAIL round_trip px%0d: got %h, want %h", n, bus.dout, rt[n]);
        end
        n++;
      end
      if (n == 16) break;
      if (wi < 2) begin
        bus.din = words[wi]; bus.din_valid = 1'b1;
      end else begin
        bus.din_valid = 1'b0;
      end
      pend = bus.din_valid && bus.din_ready;
    end
    bus.din_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (n != 16 || bus.dout_valid !== 1'b0) begin
      fails++;
      $display("FAIL round_trip_count: got %0d pixels valid=%b, want 16 and 0", n, bus.dout_valid);
    end
  endtask

  task automatic test_flush();
    bus.dout_ready = 1'b1;
    bus.din = make_word(24'h400000); bus.din_valid = 1'b1;
    @(negedge clk);
    bus.din = make_word(24'h410000); bus.din_valid = 1'b1;
    @(negedge clk);
    bus.din_valid = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (bus.dout !== 24'h400003 || bus.din_ready !== 1'b0) begin
      fails++;
      $display("FAIL flush_setup: got dout=%h ready=%b, want 400003 0", bus.dout, bus.din_ready);
    end
    flush = 1'b1;
    bus.din = make_word(24'h420000); bus.din_valid = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.dout_valid !== 1'b0 || bus.din_ready !== 1'b1 || bus.dout !== '0 || bus.dout_sof !== 1'b0) begin
      fails++;
      $display("FAIL flush_mid: got valid=%b ready=%b dout=%h sof=%b, want 0 1 0 0",
               bus.dout_valid, bus.din_ready, bus.dout, bus.dout_sof);
    end
    flush = 1'b0;
    @(negedge clk);
    bus.din_valid = 1'b0;
    tests++;
    if (bus.dout_valid !== 1'b1 || bus.dout !== 24'h420000 || bus.dout_sof !== 1'b1) begin
      fails++;
      $display("FAIL flush_restart: got valid=%b dout=%h sof=%b, want 1 420000 1",
               bus.dout_valid, bus.dout, bus.dout_sof);
    end
    flush = 1'b1;
    @(negedge clk);
    bus.din = make_word(24'h430000); bus.din_valid = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.dout_valid !== 1'b0 || bus.din_ready !== 1'b1) begin
      fails++;
      $display("FAIL flush_accept: got valid=%b ready=%b, want 0 1", bus.dout_valid, bus.din_ready);
    end
    flush = 1'b0; bus.din_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.dout_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush_dropped: got valid=%b dout=%h, want 0", bus.dout_valid, bus.dout);
    end
  endtask

  task automatic test_rst_mid();
    bus.dout_ready = 1'b1;
    bus.din = make_word(24'h500000); bus.din_valid = 1'b1;
    @(negedge clk);
    bus.din = make_word(24'h510000); bus.din_valid = 1'b1;
    @(negedge clk);
    bus.din_valid = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (bus.dout !== 24'h500003 || bus.din_ready !== 1'b0) begin
      fails++;
      $display("FAIL rst_setup: got dout=%h ready=%b, want 500003 0", bus.dout, bus.din_ready);
    end
    rst = 1'b1;
    bus.din = make_word(24'h520000); bus.din_valid = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.dout_valid !== 1'b0 || bus.din_ready !== 1'b1 || bus.dout !== '0 || bus.dout_sof !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid: got valid=%b ready=%b dout=%h sof=%b, want 0 1 0 0",
               bus.dout_valid, bus.din_ready, bus.dout, bus.dout_sof);
    end
    // Still in reset, now EMPTY with a word offered: it must be discarded.
    @(negedge clk);
    rst = 1'b0; bus.din_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (bus.dout_valid !== 1'b0) begin
        fails++;
        $display("FAIL rst_dropped cyc%0d: got valid=%b dout=%h, want 0", i, bus.dout_valid, bus.dout);
      end
      @(negedge clk);
    end
    bus.din = make_word(24'h530000); bus.din_valid = 1'b1;
    @(negedge clk);
    bus.din_valid = 1'b0;
    tests++;
    if (bus.dout_valid !== 1'b1 || bus.dout !== 24'h530000 || bus.dout_sof !== 1'b1) begin
      fails++;
      $display("FAIL rst_restart: got valid=%b dout=%h sof=%b, want 1 530000 1",
               bus.dout_valid, bus.dout, bus.dout_sof);
    end
    repeat (8) @(negedge clk);
    tests++;
    if (bus.dout_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_drain: got valid=%b, want 0", bus.dout_valid);
    end
  endtask

  initial begin
    clk = 1'b0;
    tests = 0;
    fails = 0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_back_pressure();
    test_round_trip();
    test_flush();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
